timeout_scheduler: RTL and testbench

TIMEOUT_SCHEDULER -- requirements
Module: timeout_scheduler

---
 rtl/timeout_scheduler_pkg.sv | 15 +
 rtl/timeout_scheduler_if.sv | 30 +++
 rtl/timeout_scheduler_tick_prescaler.sv | 32 +++
 rtl/timeout_scheduler.sv | 132 +++++++++++++
 tb/tb_timeout_scheduler.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/timeout_scheduler_pkg.sv
// Shared types and default constants for the timeout scheduler.
// FSM state encoding plus the parameter defaults used by top and prescaler.
package timeout_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int CLK_PER_TICK_DEF = 100000;
  localparam int DUR_W_DEF        = 6;
  localparam int N_REQ_DEF        = 4;

endpackage

// File: rtl/timeout_scheduler_if.sv
// Request/grant bundle between requesters and the shared timeout scheduler.
// master = requester side (drives req/dur), slave = scheduler side.
interface timeout_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int DUR_W = 6
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*DUR_W-1:0] dur;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic                   busy;

  modport master (
    output req,
    output dur,
    input  gnt,
    input  done,
    input  busy
  );

  modport slave (
    input  req,
    input  dur,
    output gnt,
    output done,
    output busy
  );

endinterface

// File: rtl/timeout_scheduler_tick_prescaler.sv
// Free-running divider: tick is high on the cycle the count wraps at CLK_PER_TICK-1.
// Latency: first tick CLK_PER_TICK cycles after clr; backpressure: none, en simply freezes the count.
module tick_prescaler
  import timeout_scheduler_pkg::*;
#(
  parameter int CLK_PER_TICK = CLK_PER_TICK_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int              CNT_W = $clog2(CLK_PER_TICK);
  localparam logic [CNT_W-1:0] WRAP = CNT_W'(CLK_PER_TICK - 1);

  logic [CNT_W-1:0] r_cnt;

  assign tick = en && (r_cnt == WRAP);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/timeout_scheduler.sv
// Round-robin shared timer: grants one requester, counts dur ticks, pulses done.
// Latency: gnt 1 cycle after req, done dur*CLK_PER_TICK cycles after grant; backpressure: losers hold req level.
module timeout_scheduler
  import timeout_scheduler_pkg::*;
#(
  parameter int CLK_PER_TICK = CLK_PER_TICK_DEF,
  parameter int N_REQ        = N_REQ_DEF,
  parameter int DUR_W        = DUR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  timeout_scheduler_if.slave tmr
);

  localparam int               IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] w_gnt_nxt;
  logic [N_REQ-1:0] r_done;
  logic [N_REQ-1:0] w_done_nxt;
  logic [DUR_W-1:0] r_cnt;
  logic [DUR_W-1:0] w_cnt_nxt;
  logic [IDX_W-1:0] r_last;
  logic [IDX_W-1:0] w_last_nxt;

  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_win;
  logic             w_win_vld;
  logic [DUR_W-1:0] w_win_dur;
  logic             w_grant;
  logic             w_presc_en;
  logic             w_tick;

  // Walk offsets from far to near so the requester just after r_last wins.
  always_comb begin
    w_idx     = r_last;
    w_win     = r_last;
    w_win_vld = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = IDX_W'((int'(r_last) + k) % N_REQ);
      if (tmr.req[w_idx]) begin
        w_win     = w_idx;
        w_win_vld = 1'b1;
      end
    end
  end

  assign w_win_dur  = tmr.dur[int'(w_win)*DUR_W +: DUR_W];
  assign w_grant    = (r_state == ST_IDLE) && w_win_vld;
  assign w_presc_en = (r_state == ST_COUNT);

  tick_prescaler #(
    .CLK_PER_TICK (CLK_PER_TICK)
  ) u_tick_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (w_grant),
    .en    (w_presc_en),
    .tick  (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = '0;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    unique case (r_state)
      ST_IDLE: begin
        if (w_win_vld) begin
          w_last_nxt = w_win;
          if (w_win_dur != '0) begin
            w_state_nxt = ST_COUNT;
            w_gnt_nxt   = N_REQ'(1) << w_win;
            w_cnt_nxt   = w_win_dur;
          end else begin
            w_state_nxt = ST_DONE;
            w_gnt_nxt   = '0;
            w_done_nxt  = N_REQ'(1) << w_win;
          end
        end
      end
      ST_COUNT: begin
        // A dropped request beats a coincident final tick: no done pulse.
        if (!tmr.req[r_last]) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = '0;
        end else if (w_tick) begin
          if (r_cnt == DUR_W'(1)) begin
            w_state_nxt = ST_DONE;
            w_gnt_nxt   = '0;
            w_done_nxt  = N_REQ'(1) << r_last;
          end else begin
            w_cnt_nxt = r_cnt - DUR_W'(1);
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_cnt   <= '0;
      r_last  <= LAST_RST;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign tmr.gnt  = r_gnt;
  assign tmr.done = r_done;
  assign tmr.busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_timeout_scheduler.sv
// Directed bench for timeout_scheduler (CLK_PER_TICK=4, N_REQ=4, DUR_W=6).
// Stimulus queues expected gnt/done events with absolute cycle stamps; a monitor pops and compares.
module tb_timeout_scheduler;

  localparam int CPT = 4;
  localparam int NR  = 4;
  localparam int DW  = 6;

  typedef struct {
    bit            is_done;
    logic [NR-1:0] mask;
    int            cyc;
  } exp_t;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  int            cyc   = 0;
  int            n_tests = 0;
  int            n_fail  = 0;
  exp_t          sb[$];
  logic [NR-1:0] prev_gnt = '0;

  timeout_scheduler_if #(.N_REQ(NR), .DUR_W(DW)) tmr();

  timeout_scheduler #(
    .CLK_PER_TICK (CPT),
    .N_REQ        (NR),
    .DUR_W        (DW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .tmr   (tmr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input bit is_done, input logic [NR-1:0] mask, input int at);
    exp_t e;
    e.is_done = is_done;
    e.mask    = mask;
    e.cyc     = at;
    sb.push_back(e);
  endtask

  task automatic observe(input bit is_done, input logic [NR-1:0] mask);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_%s: got mask %b at cycle %0d, required no event",
               is_done ? "done" : "gnt", mask, cyc);
    end else begin
      e = sb.pop_front();
      check(is_done ? "ev_kind_done" : "ev_kind_gnt", 32'(is_done), 32'(e.is_done));
      check("ev_mask", 32'(mask), 32'(e.mask));
      check("ev_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    check("gnt_done_excl", 32'((tmr.gnt != '0) && (tmr.done != '0)), 32'd0);
    check("gnt_onehot0", 32'($onehot0(tmr.gnt)), 32'd1);
    check("done_onehot0", 32'($onehot0(tmr.done)), 32'd1);
    if ((tmr.gnt != '0) && (tmr.gnt != prev_gnt)) observe(1'b0, tmr.gnt);
    if (tmr.done != '0) observe(1'b1, tmr.done);
    prev_gnt = tmr.gnt;
  end

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_dur(input int i, input int v);
    tmr.dur[i*DW +: DW] = DW'(v);
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_gnt"}, 32'(tmr.gnt), 32'd0);
    check({tag, "_done"}, 32'(tmr.done), 32'd0);
    check({tag, "_busy"}, 32'(tmr.busy), 32'd0);
  endtask

  initial begin
    tmr.req = '0;
    tmr.dur = '0;

    // Reset state
    goto(3);
    check_idle_outs("reset");
    reset = 1'b0;

    // Single requester, dur=3: gnt at +1, done 12 cycles after the grant edge
    goto(5);
    tmr.req = 4'b0001;
    set_dur(0, 3);
    expect_ev(1'b0, 4'b0001, 6);
    expect_ev(1'b1, 4'b0001, 18);
    goto(6);  check("a_busy_grant", 32'(tmr.busy), 32'd1);
    goto(12); check("a_busy_mid", 32'(tmr.busy), 32'd1);
    goto(18); check("a_busy_done", 32'(tmr.busy), 32'd1);
    tmr.req = '0;
    goto(19); check("a_busy_after", 32'(tmr.busy), 32'd0);

    // Zero duration: no grant, done on the cycle after the grant edge
    goto(21);
    tmr.req = 4'b0100;
    set_dur(2, 0);
    expect_ev(1'b1, 4'b0100, 22);
    goto(22);
    check("b_gnt_zero", 32'(tmr.gnt), 32'd0);
    check("b_busy", 32'(tmr.busy), 32'd1);
    tmr.req = '0;
    goto(23); check("b_busy_after", 32'(tmr.busy), 32'd0);

    // Cancel mid-count; dur change after the grant must be ignored
    goto(25);
    tmr.req = 4'b0010;
    set_dur(1, 5);
    expect_ev(1'b0, 4'b0010, 26);
    goto(27); set_dur(1, 1);
    goto(32); tmr.req = '0;
    goto(33); check_idle_outs("c_cancel");

    // Cancel coincident with the final tick wins
    goto(35);
    tmr.req = 4'b0001;
    set_dur(0, 1);
    expect_ev(1'b0, 4'b0001, 36);
    goto(39); tmr.req = '0;
    goto(40); check_idle_outs("d_cancel_tick");

    // Reset mid-count, then all four request with dur=1
    goto(42);
    tmr.req = 4'b0100;
    set_dur(2, 3);
    expect_ev(1'b0, 4'b0100, 43);
    goto(45); reset = 1'b1;
    goto(46);
    check_idle_outs("e_reset");
    reset = 1'b0;
    tmr.req = 4'b1111;
    for (int i = 0; i < NR; i++) set_dur(i, 1);
    for (int j = 0; j < 5; j++) begin
      expect_ev(1'b0, NR'(1) << (j % NR), 47 + 6*j);
      expect_ev(1'b1, NR'(1) << (j % NR), 51 + 6*j);
    end
    goto(76); tmr.req = '0;
    goto(78); check("e_busy_after", 32'(tmr.busy), 32'd0);

    // last=0 with req=0011: requester 1 first, then 0
    goto(80);
    tmr.req = 4'b0011;
    set_dur(0, 1);
    set_dur(1, 2);
    expect_ev(1'b0, 4'b0010, 81);
    expect_ev(1'b1, 4'b0010, 89);
    expect_ev(1'b0, 4'b0001, 91);
    expect_ev(1'b1, 4'b0001, 95);
    goto(95); tmr.req = '0;
    goto(100); check("f_busy_after", 32'(tmr.busy), 32'd0);

    goto(105);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
